// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the instruction-memory port, the redirect input and
// the decode-facing output register of the fetch stage.
// master = fetch stage side, slave = memory/decode/branch environment side.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [6:0]  id_op;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    input  id_ready,
    output id_valid, id_instr, id_pc, id_pc_plus4,
    output id_op, id_funct3, id_funct7b5
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    output id_ready,
    input  id_valid, id_instr, id_pc, id_pc_plus4,
    input  id_op, id_funct3, id_funct7b5
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one PC register, at most one outstanding
// memory request and a registered output toward decode.
// Build option: define FETCH_SKID_BUF_EN to add a one-entry skid buffer that
// lets a 1-cycle-latency memory sustain one instruction per cycle; without it
// a new fetch is only issued when the output register is free at cycle end.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  localparam logic [31:0] PC_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'h0000_0004;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // nothing outstanding
    WAIT  = 2'd1,  // one request outstanding, response wanted
    DRAIN = 2'd2   // one request outstanding, response to be thrown away
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic [31:0] req_pc_r;
  logic        id_valid_r;
  logic [31:0] id_instr_r;
  logic [31:0] id_pc_r;
  logic [31:0] id_pc_plus4_r;
  logic        transfer_s;
  logic        out_hold_s;
  logic        capture_s;
  logic        issue_ok_s;
  logic        issue_s;
`ifdef FETCH_SKID_BUF_EN
  logic        skid_valid_r;
  logic [31:0] skid_instr_r;
  logic [31:0] skid_pc_r;
`endif

  // Handshake qualifiers shared by the FSM and the storage registers.
  assign transfer_s = id_valid_r & bus.id_ready;
  assign out_hold_s = id_valid_r & ~bus.id_ready;
  assign capture_s  = (state_r == WAIT) & bus.imem_rvalid & ~bus.redirect_valid;

`ifdef FETCH_SKID_BUF_EN
  // A fetch may go out whenever the skid entry will be empty at cycle end,
  // so its response always has somewhere to land.
  assign issue_ok_s = ~((skid_valid_r & ~transfer_s) | (capture_s & out_hold_s));
`else
  // A fetch may go out only when the output register will be empty at cycle end.
  assign issue_ok_s = ~(capture_s | out_hold_s);
`endif

  // Issue from IDLE, or back-to-back from WAIT when the response lands this cycle.
  assign issue_s = ~reset & ~bus.redirect_valid & issue_ok_s &
                   ((state_r == IDLE) | capture_s);

  assign bus.imem_req    = issue_s;
  assign bus.imem_addr   = pc_r;
  assign bus.id_valid    = id_valid_r;
  assign bus.id_instr    = id_instr_r;
  assign bus.id_pc       = id_pc_r;
  assign bus.id_pc_plus4 = id_pc_plus4_r;
  assign bus.id_op       = id_instr_r[6:0];
  assign bus.id_funct3   = id_instr_r[14:12];
  assign bus.id_funct7b5 = id_instr_r[30];

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: track whether the outstanding response is wanted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_next_s = issue_s ? WAIT : IDLE;
        end else if (bus.redirect_valid) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = WAIT;
        end
      end
      DRAIN: begin
        if (bus.imem_rvalid) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Fetch PC and the address of the request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r     <= RESET_PC & PC_MASK;
      req_pc_r <= RESET_PC & PC_MASK;
    end else if (bus.redirect_valid) begin
      pc_r     <= bus.redirect_pc & PC_MASK;
      req_pc_r <= req_pc_r;
    end else if (issue_s) begin
      pc_r     <= pc_r + PC_STEP;
      req_pc_r <= pc_r;
    end else begin
      pc_r     <= pc_r;
      req_pc_r <= req_pc_r;
    end
  end

  // Output register toward decode: load a response, refill from skid, or drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_r    <= 1'b0;
      id_instr_r    <= NOP_INSTR;
      id_pc_r       <= 32'h0000_0000;
      id_pc_plus4_r <= 32'h0000_0000;
    end else if (bus.redirect_valid) begin
      id_valid_r    <= 1'b0;
    end else if (capture_s && !out_hold_s) begin
      id_valid_r    <= 1'b1;
      id_instr_r    <= bus.imem_rdata;
      id_pc_r       <= req_pc_r;
      id_pc_plus4_r <= req_pc_r + PC_STEP;
`ifdef FETCH_SKID_BUF_EN
    end else if (transfer_s && skid_valid_r) begin
      id_valid_r    <= 1'b1;
      id_instr_r    <= skid_instr_r;
      id_pc_r       <= skid_pc_r;
      id_pc_plus4_r <= skid_pc_r + PC_STEP;
`endif
    end else if (transfer_s) begin
      id_valid_r    <= 1'b0;
    end else begin
      id_valid_r    <= id_valid_r;
    end
  end

`ifdef FETCH_SKID_BUF_EN
  // Skid entry: parks a response that arrives while decode is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_r <= 1'b0;
      skid_instr_r <= NOP_INSTR;
      skid_pc_r    <= 32'h0000_0000;
    end else if (bus.redirect_valid) begin
      skid_valid_r <= 1'b0;
    end else if (capture_s && out_hold_s) begin
      skid_valid_r <= 1'b1;
      skid_instr_r <= bus.imem_rdata;
      skid_pc_r    <= req_pc_r;
    end else if (transfer_s) begin
      skid_valid_r <= 1'b0;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, cycle-by-cycle test of fetch_stage with
// RESET_PC = 0x100. The memory side is driven by hand; every expected value
// is written out for the cycle it is checked in.
module tb_fetch_stage;

  logic clk;
  logic reset;
  int   nvec;
  int   nmis;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    reset = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0000_0000;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0000_0000;
    bus.id_ready       = 1'b1;
    tick;
    tick;
    chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_instr", bus.id_instr, 32'h0000_0013);
    chk("rst_pc",    bus.id_pc, 32'h0000_0000);
    chk("rst_pc4",   bus.id_pc_plus4, 32'h0000_0000);
    chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);

    // First cycle after release: fetch RESET_PC.
    reset = 1'b0;
    #1;
    chk("c0_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("c0_addr", bus.imem_addr, 32'h0000_0100);

`ifdef FETCH_SKID_BUF_EN
    // Back-to-back responses: one fetch per cycle.
    tick; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00A0_0093; #1;
    chk("s1_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("s1_addr", bus.imem_addr, 32'h0000_0104);
    tick; bus.imem_rdata = 32'h40B5_0533; #1;
    chk("s2_pc",   bus.id_pc, 32'h0000_0100);
    chk("s2_op",   {25'd0, bus.id_op}, 32'h0000_0013);
    chk("s2_addr", bus.imem_addr, 32'h0000_0108);
    chk("s2_req",  {31'd0, bus.imem_req}, 32'd1);
    // Response arrives while decode stalls: it goes to the skid entry.
    tick; bus.imem_rdata = 32'h0010_8113; bus.id_ready = 1'b0; #1;
    chk("s3_pc",   bus.id_pc, 32'h0000_0104);
    chk("s3_req",  {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick; bus.imem_rvalid = 1'b0; #1;
      chk("s_stall_pc",    bus.id_pc, 32'h0000_0104);
      chk("s_stall_instr", bus.id_instr, 32'h40B5_0533);
      chk("s_stall_f7b5",  {31'd0, bus.id_funct7b5}, 32'd1);
      chk("s_stall_req",   {31'd0, bus.imem_req}, 32'd0);
    end
    // Release: skid drains into the output register, fetching resumes.
    tick; bus.id_ready = 1'b1; #1;
    chk("s_rel_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("s_rel_addr", bus.imem_addr, 32'h0000_010C);
    tick; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0020_0193; #1;
    chk("s_skid_pc",    bus.id_pc, 32'h0000_0108);
    chk("s_skid_instr", bus.id_instr, 32'h0010_8113);
    chk("s_skid_pc4",   bus.id_pc_plus4, 32'h0000_010C);
    tick; bus.imem_rvalid = 1'b0; #1;
    chk("s_next_pc",    bus.id_pc, 32'h0000_010C);
    chk("s_next_instr", bus.id_instr, 32'h0020_0193);
    bus.id_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("s_rst_valid", {31'd0, bus.id_valid}, 32'd0);
`else
    // 1-cycle memory, no skid: one instruction every two cycles.
    tick; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00A0_0093; #1;
    chk("c1_req", {31'd0, bus.imem_req}, 32'd0);
    tick; bus.imem_rvalid = 1'b0; #1;
    chk("c2_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("c2_instr", bus.id_instr, 32'h00A0_0093);
    chk("c2_pc",    bus.id_pc, 32'h0000_0100);
    chk("c2_pc4",   bus.id_pc_plus4, 32'h0000_0104);
    chk("c2_op",    {25'd0, bus.id_op}, 32'h0000_0013);
    chk("c2_f3",    {29'd0, bus.id_funct3}, 32'd0);
    chk("c2_f7b5",  {31'd0, bus.id_funct7b5}, 32'd0);
    chk("c2_req",   {31'd0, bus.imem_req}, 32'd1);
    chk("c2_addr",  bus.imem_addr, 32'h0000_0104);
    tick; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h40B5_0533; #1;
    chk("c3_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("c3_req",   {31'd0, bus.imem_req}, 32'd0);
    tick; bus.imem_rvalid = 1'b0; #1;
    chk("c4_instr", bus.id_instr, 32'h40B5_0533);
    chk("c4_pc",    bus.id_pc, 32'h0000_0104);
    chk("c4_pc4",   bus.id_pc_plus4, 32'h0000_0108);
    chk("c4_op",    {25'd0, bus.id_op}, 32'h0000_0033);
    chk("c4_f3",    {29'd0, bus.id_funct3}, 32'd0);
    chk("c4_f7b5",  {31'd0, bus.id_funct7b5}, 32'd1);
    chk("c4_addr",  bus.imem_addr, 32'h0000_0108);
    tick; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0010_8113; #1;
    // Decode stalls for 5 cycles holding the instruction at 0x108.
    tick; bus.imem_rvalid = 1'b0; bus.id_ready = 1'b0; #1;
    chk("st_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("st_pc",    bus.id_pc, 32'h0000_0108);
    chk("st_req",   {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick; #1;
      chk("stall_valid", {31'd0, bus.id_valid}, 32'd1);
      chk("stall_pc",    bus.id_pc, 32'h0000_0108);
      chk("stall_instr", bus.id_instr, 32'h0010_8113);
      chk("stall_req",   {31'd0, bus.imem_req}, 32'd0);
    end
    tick; bus.id_ready = 1'b1; #1;
    chk("rel_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("rel_addr", bus.imem_addr, 32'h0000_010C);
    chk("rel_pc",   bus.id_pc, 32'h0000_0108);
    // Redirect to 0x203 while the fetch of 0x10C is outstanding.
    tick; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0203; #1;
    chk("rd_nodup", {31'd0, bus.id_valid}, 32'd0);
    chk("rd_req",   {31'd0, bus.imem_req}, 32'd0);
    tick; bus.redirect_valid = 1'b0; #1;
    chk("dr1_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("dr1_req",   {31'd0, bus.imem_req}, 32'd0);
    tick; #1;
    chk("dr2_req",   {31'd0, bus.imem_req}, 32'd0);
    tick; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; #1;
    chk("dr3_req",   {31'd0, bus.imem_req}, 32'd0);
    tick; bus.imem_rvalid = 1'b0; #1;
    chk("rf_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rf_req",   {31'd0, bus.imem_req}, 32'd1);
    chk("rf_addr",  bus.imem_addr, 32'h0000_0200);
    tick; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0293; #1;
    chk("rf_wait_valid", {31'd0, bus.id_valid}, 32'd0);
    // Redirect while the output is being accepted still flushes it.
    tick; bus.imem_rvalid = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF; #1;
    chk("tx_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("tx_pc",    bus.id_pc, 32'h0000_0200);
    chk("tx_instr", bus.id_instr, 32'h0050_0293);
    chk("tx_req",   {31'd0, bus.imem_req}, 32'd0);
    tick; bus.redirect_valid = 1'b0; #1;
    chk("fl_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("wr_req",   {31'd0, bus.imem_req}, 32'd1);
    chk("wr_addr",  bus.imem_addr, 32'hFFFF_FFFC);
    tick; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0073; #1;
    tick; bus.imem_rvalid = 1'b0; #1;
    chk("wr_pc",     bus.id_pc, 32'hFFFF_FFFC);
    chk("wr_pc4",    bus.id_pc_plus4, 32'h0000_0000);
    chk("wr_next",   bus.imem_addr, 32'h0000_0000);
    chk("wr_nreq",   {31'd0, bus.imem_req}, 32'd1);
    // Reset in the middle of the outstanding fetch of 0x0.
    tick; reset = 1'b1; #1;
    chk("mr_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("mr_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("mr_addr",  bus.imem_addr, 32'h0000_0100);
    // Late response right after release must be ignored.
    tick; reset = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0; #1;
    chk("lr_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("lr_addr", bus.imem_addr, 32'h0000_0100);
    tick; bus.imem_rvalid = 1'b0; #1;
    chk("lr_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("lr_wreq",  {31'd0, bus.imem_req}, 32'd0);
    tick; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00A0_0093; #1;
    tick; bus.imem_rvalid = 1'b0; bus.id_ready = 1'b0; #1;
    chk("rr_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("rr_pc",    bus.id_pc, 32'h0000_0100);
    chk("rr_instr", bus.id_instr, 32'h00A0_0093);
    // Reset clears a valid output register without waiting for a clock.
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("ar_instr", bus.id_instr, 32'h0000_0013);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide RESET_PC, 32'h0000_0000, first fetch address after reset.
Ports (name, direction, width, meaning):
REQ-002 SHALL provide clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL provide reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL provide imem_req, output, 1, one-cycle pulse issuing a fetch at imem_addr.
REQ-005 SHALL provide imem_addr, output, 32, fetch address; bits [1:0] always 2'b00.
REQ-006 SHALL provide imem_rvalid, input, 1, response strobe, at least 1 cycle after imem_req.
REQ-007 SHALL provide imem_rdata, input, 32, instruction word, valid with imem_rvalid.
REQ-008 SHALL provide redirect_valid, input, 1, branch/jump taken: flush and refetch.
REQ-009 SHALL provide redirect_pc, input, 32, redirect target; bits [1:0] ignored, treated as 00.
REQ-010 SHALL provide id_ready, input, 1, downstream accepts the output register this cycle.
REQ-011 SHALL provide id_valid, output, 1, output register holds a valid instruction.
REQ-012 SHALL provide id_instr, output, 32, registered instruction.
REQ-013 SHALL provide id_pc / id_pc_plus4, output, 32 each, its address and address+4 (mod 2^32).
REQ-014 SHALL provide id_op [6:0], id_funct3 [2:0], id_funct7b5 [0], output, combinational slices id_instr[6:0], [14:12], [30] feeding the control unit.

Function
REQ-015 SHALL hold one fetch PC register and at most one outstanding imem request.
REQ-016 SHALL implement FSM IDLE (nothing outstanding), WAIT (request outstanding), DRAIN (outstanding response to discard).
REQ-017 IDLE: SHALL assert imem_req with imem_addr=pc, pc<=pc+4 (wraps 32'hFFFF_FFFC->0), go WAIT, when no redirect and the issue condition holds (REQ-023/024).
REQ-018 WAIT: on imem_rvalid SHALL capture {imem_rdata, pc_of_request, +4} into output register (or skid, REQ-024), go IDLE; same-cycle new issue allowed if issue condition holds.
REQ-019 DRAIN: on imem_rvalid SHALL discard data, go IDLE; no capture.
REQ-020 Output handshake: entry transfers when id_valid && id_ready; id_valid SHALL hold and outputs stay stable while id_ready=0.
REQ-021 Redirect (priority over all except reset): pc<=redirect_pc&~3, id_valid<=0, skid cleared, no imem_req that cycle; WAIT->DRAIN; WAIT with imem_rvalid same cycle -> IDLE, data discarded; DRAIN stays DRAIN unless rvalid.
REQ-022 Redirect while id_valid && id_ready SHALL still flush (downstream owns that transfer's validity).
REQ-023 Issue condition without skid: output register empty at end of cycle (id_valid=0 or id_ready=1); guarantees no response lost.
REQ-024 Responses SHALL never be dropped except by redirect/DRAIN; imem_rvalid in IDLE is illegal and ignored.

Reset
REQ-025 reset asserted SHALL immediately force: pc=RESET_PC, state IDLE, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc_plus4=0, imem_req=0, skid empty.
REQ-026 First imem_req SHALL occur in the first cycle after reset deasserts, addr=RESET_PC.
REQ-027 Reset mid-WAIT SHALL abandon the request; a late imem_rvalid after reset is ignored (state IDLE).

Configuration
REQ-028 Macro FETCH_SKID_BUF_EN: defined -> one-entry skid buffer; issue condition becomes skid empty; response arriving while output register full and not consumed goes to skid; skid moves to output register on next transfer; back-to-back 1-cycle-latency fetch sustains 1 instr/cycle.
REQ-029 Undefined -> no skid storage; REQ-023 issue rule; max throughput 1 instr per 2 cycles at 1-cycle latency.

Verification
REQ-030 Reset release, RESET_PC=0x100, 1-cycle memory, id_ready=1 -> imem_addr 0x100,0x104,0x108; id_pc follows, id_pc_plus4=id_pc+4.
REQ-031 imem_rdata=0x00A00093 captured -> id_op=0x13, id_funct3=0, id_funct7b5=0; 0x40B50533 -> op 0x33, funct3 0, funct7b5 1.
REQ-032 id_ready=0 for 5 cycles with id_valid=1 -> id_instr/id_pc unchanged, no lost or duplicated instruction after release (both macro settings).
REQ-033 redirect_valid, redirect_pc=0x203 during WAIT, response 3 cycles later -> response discarded, next imem_addr=0x200, id_valid=0 until its data arrives.
REQ-034 pc=0xFFFF_FFFC fetch -> next imem_addr=0x0; reset asserted mid-WAIT -> id_valid=0 immediately, refetch from RESET_PC.
